instr_fetch_unit: RTL

//  Fetch stage of KGP-miniRISC: owns the PC, fetches 32-bit instructions from instruction memory over a req/valid handshake,

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - KGP-miniRISC fetch stage: PC, imem req/valid handshake, instruction register
// Optional halt detection is compiled in when HALT_DETECT_EN is defined.
module instr_fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] link_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_target;
  logic              capture;
  logic              halt_hit;

  assign pc_inc          = pc + ADDR_W'(4);
  assign redirect_target = redirect_pc & ~ADDR_W'(3);
  assign halt_hit        = HALT_EN && (imem_rdata[31:26] == HALT_OPCODE);

  // Request is gated by reset so nothing reaches imem while the PC is being reloaded.
  assign imem_req  = rst && (state == S_FETCH || state == S_WAIT);
  assign imem_addr = rst ? pc : RESET_PC;
  assign opcode    = instr[31:26];
  assign func      = instr[5:0];

  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    unique case (state)
      S_FETCH, S_WAIT: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          // A WAIT with no response yet still owes one beat; it must be swallowed.
          state_next = (state == S_WAIT && !imem_valid) ? S_DRAIN : S_FETCH;
        end else if (imem_valid) begin
          capture    = 1'b1;
          pc_next    = pc_inc;
          state_next = halt_hit ? S_HALTED : S_HOLD;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = S_FETCH;
        end else if (instr_ready) begin
          state_next = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_next = redirect_target;
        if (imem_valid) state_next = S_FETCH;
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      link_pc     <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_valid <= (state_next == S_HOLD);
      halted      <= (state_next == S_HALTED);
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
        link_pc  <= pc_inc;
      end
    end
  end

endmodule
